csa_cpa_pipe: RTL and testbench
===============================

Name: csa_cpa_pipe

Overview:
- Carry-propagate stage directly downstream of the 8/8/11 3:2 carry-save compressor.
- Takes the compressor's sum vector (11 bits) and its left-shifted carry vector (9 bits, bit 1 always zero) and resolves them into one binary result.
- Two-stage pipeline: low slice in stage 1, high slice plus carry-in in stage 2.
- Valid/ready handshake on both sides, so it can be backpressured by the consumer.

Parameters:
- S_WIDTH, 11, width of incoming sum vector
- C_WIDTH, 9, width of incoming carry vector; must satisfy C_WIDTH <= S_WIDTH
- SPLIT, 6, bits resolved in stage 1; must satisfy 1 <= SPLIT < C_WIDTH

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_s/in_c valid this cycle
- in_ready  out  1  block accepts input this cycle
- in_s  in  [S_WIDTH:1]  sum vector from compressor
- in_c  in  [C_WIDTH:1]  carry vector from compressor
- out_valid  out  1  out_sum valid
- out_ready  in  1  consumer accepts out_sum this cycle
- out_sum  out  [S_WIDTH+1:1]  in_s + zero-extended in_c, full precision

Behaviour:
- One clock; reset is asynchronous, active-low (rst_n).
  - While rst_n is low: all stage registers clear, out_valid=0, out_sum=0.
  - in_ready=0 during reset, combinationally.
- Arithmetic: out_sum = in_s + {zeros, in_c}, width S_WIDTH+1, never truncated. Defaults give max 2047+511=2558, which fits in 12 bits.
- Stage 1 (s1), on accept:
  - Register lo = in_s[SPLIT:1] + in_c[SPLIT:1], a SPLIT+1-bit result whose top bit is c_mid.
  - Register the high operand slices in_s[S_WIDTH:SPLIT+1] and in_c[C_WIDTH:SPLIT+1], zero-extended.
  - Set s1_valid.
- Stage 2 (s2 = output register):
  - out_sum[SPLIT:1] = lo[SPLIT:1].
  - out_sum[S_WIDTH+1:SPLIT+1] = hi_s + hi_c + c_mid.
  - out_valid = s2_valid.
- Handshake / flow:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no skid buffer).
  - s2 loads from s1 when s1_valid && s2_adv; s2_valid clears when it drains with no s1 data.
  - s1 loads on input transfer; s1_valid clears when s1 moves to s2 with no new input.
- Latency: 2 cycles from accepted input to out_valid. Throughput: 1 result per cycle with out_ready held high.
- Ordering: strict FIFO. Capacity is 2 items, one in s1 and one in s2.
- Stalls:
  - out_ready=0 with both stages full: in_ready=0, all registers hold, out_sum is stable.
  - out_valid never drops without a transfer.
- Simultaneous accept and drain in the same cycle is legal; no bubble is inserted.
- Data registers may hold stale values when their valid bit is 0, except in reset, where they clear.
- Reset mid-operation discards in-flight items; the first accept after release behaves as from empty.

Optional Feature:
- Macro CSA_CPA_ERR_EN.
- Defined:
  - Adds output port err_sticky (1 bit).
  - err_sticky goes high the cycle after an input transfer with in_c[1]==1, which violates the upstream contract that carry bit 1 is always zero.
  - Once set it stays high until rst_n is asserted; reset value 0.
  - Arithmetic is unaffected: the value is still added as given.
- Undefined: no err_sticky port and no check logic.

Test Plan:
- Basic add: in_s=11'h7FF, in_c=9'h1FE, out_ready=1 -> two cycles later out_valid=1, out_sum=12'h9FD.
- Split-carry crossing: in_s=11'h03F, in_c=9'h002 -> out_sum=12'h041; c_mid carries into the high slice.
- Streaming: 8 back-to-back inputs with out_ready=1 -> in_ready stays 1, results appear on consecutive cycles starting at cycle 2, in order.
- Backpressure: out_ready=0, offer items A=(5,2), B=(10,4), C=(1,0):
  - A and B are accepted, then in_ready=0 and C is held.
  - out_sum=7 stays stable.
  - Raise out_ready -> outputs 7, 14, 1 in order with no loss or duplication.
- Reset mid-operation: assert rst_n=0 while out_valid=1 -> out_valid=0 and out_sum=0 immediately (asynchronous). After release, a new input (3,4) produces 7 after 2 cycles.
- CSA_CPA_ERR_EN defined: send in_c=9'h001, in_s=0 -> out_sum=1 and err_sticky=1 the next cycle. err_sticky stays 1 across later clean inputs until reset.

Source files
------------

// File: rtl/csa_cpa_pipe_if.sv
// Valid/ready bus between the 3:2 compressor, the carry-propagate pipe and its consumer.
// slave = pipe side, master = the driver/consumer side.
interface csa_cpa_pipe_if #(
  parameter int unsigned S_WIDTH = 11,
  parameter int unsigned C_WIDTH = 9
) ();
  logic               in_valid;
  logic               in_ready;
  logic [S_WIDTH:1]   in_s;
  logic [C_WIDTH:1]   in_c;
  logic               out_valid;
  logic               out_ready;
  logic [S_WIDTH+1:1] out_sum;

  modport slave (
    input  in_valid, in_s, in_c, out_ready,
    output in_ready, out_valid, out_sum
  );

  modport master (
    output in_valid, in_s, in_c, out_ready,
    input  in_ready, out_valid, out_sum
  );
endinterface

// File: rtl/csa_cpa_pipe.sv
// Two-stage carry-propagate adder resolving a carry-save sum/carry pair into one binary result.
// Optional macro CSA_CPA_ERR_EN adds a sticky flag for a set carry bit 1 on accepted input.
module csa_cpa_pipe #(
  parameter int unsigned S_WIDTH = 11,
  parameter int unsigned C_WIDTH = 9,
  parameter int unsigned SPLIT   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  csa_cpa_pipe_if.slave     bus
`ifdef CSA_CPA_ERR_EN
  ,
  output logic              err_sticky
`endif
);

  localparam int unsigned HiW = S_WIDTH + 1 - SPLIT;
  localparam int unsigned HsW = S_WIDTH - SPLIT;
  localparam int unsigned HcW = C_WIDTH - SPLIT;

  logic                 s1_valid_q;
  logic                 s2_valid_q;
  logic [SPLIT+1:1]     lo_q;
  logic [SPLIT+1:1]     lo_d;
  logic [HsW:1]         hi_s_q;
  logic [HcW:1]         hi_c_q;
  logic [HiW:1]         hi_d;
  logic [S_WIDTH+1:1]   sum_q;

  logic s1_adv;
  logic s2_adv;
  logic in_xfer;
  logic s2_load;

  always_comb begin
    s2_adv  = !s2_valid_q || bus.out_ready;
    s1_adv  = !s1_valid_q || s2_adv;
    in_xfer = bus.in_valid && bus.in_ready;
    s2_load = s1_valid_q && s2_adv;
    lo_d    = {1'b0, bus.in_s[SPLIT:1]} + {1'b0, bus.in_c[SPLIT:1]};
    // Top bit of lo_q is the carry out of the low slice.
    hi_d    = HiW'(hi_s_q) + HiW'(hi_c_q) + HiW'(lo_q[SPLIT+1]);
  end

  // Held low in reset so nothing is accepted while the pipe is being cleared.
  assign bus.in_ready  = rst_n && s1_adv;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_sum   = sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      lo_q       <= '0;
      hi_s_q     <= '0;
      hi_c_q     <= '0;
      sum_q      <= '0;
    end else begin
      if (in_xfer) begin
        lo_q   <= lo_d;
        hi_s_q <= bus.in_s[S_WIDTH:SPLIT+1];
        hi_c_q <= bus.in_c[C_WIDTH:SPLIT+1];
      end
      if (s1_adv) begin
        s1_valid_q <= in_xfer;
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
      end
      if (s2_load) begin
        sum_q <= {hi_d, lo_q[SPLIT:1]};
      end
    end
  end

`ifdef CSA_CPA_ERR_EN
  logic err_sticky_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_q <= 1'b0;
    end else if (in_xfer && bus.in_c[1]) begin
      err_sticky_q <= 1'b1;
    end
  end

  assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_csa_cpa_pipe.sv
// Randomized self-checking bench for csa_cpa_pipe against a queue-based FIFO/latency model.
module tb_csa_cpa_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csa_cpa_pipe_if #(.S_WIDTH(11), .C_WIDTH(9)) bus ();

`ifdef CSA_CPA_ERR_EN
  logic err_sticky;
`endif

  csa_cpa_pipe #(
    .S_WIDTH(11),
    .C_WIDTH(9),
    .SPLIT  (6)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef CSA_CPA_ERR_EN
    ,
    .err_sticky(err_sticky)
`endif
  );

  typedef struct {
    logic [11:0] sum;
    int          t;
  } item_t;

  item_t       q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic        acc;
  logic [11:0] last_out;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: check mid-cycle against the model, update it, then cross the edge.
  task automatic step();
    item_t it;
    logic  ov_exp;
    @(negedge clk);
    ov_exp = (q.size() > 0) && (cyc - q[0].t >= 2);
    check_eq("in_ready", 32'(bus.in_ready), 32'(q.size() < 2 || bus.out_ready));
    check_eq("out_valid", 32'(bus.out_valid), 32'(ov_exp));
    if (bus.out_valid && q.size() > 0) begin
      check_eq("out_sum", 32'(bus.out_sum), 32'(q[0].sum));
      if (bus.out_ready) begin
        last_out = bus.out_sum;
        void'(q.pop_front());
      end
    end
    acc = bus.in_valid && bus.in_ready;
    if (acc) begin
      it.sum = 12'(bus.in_s) + 12'(bus.in_c);
      it.t   = cyc;
      q.push_back(it);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(input logic [10:0] s, input logic [8:0] c);
    bus.in_s     = s;
    bus.in_c     = c;
    bus.in_valid = 1'b1;
    acc          = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (acc) break;
    end
    if (!acc) check_eq("send_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      step();
    end
    check_eq("drain_empty", 32'(q.size()), 32'd0);
    step();
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_sum", 32'(bus.out_sum), 32'd0);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
    q.delete();
    @(posedge clk);
    @(posedge clk);
    cyc += 2;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    bus.in_valid  = 1'b0;
    bus.in_s      = '0;
    bus.in_c      = '0;
    bus.out_ready = 1'b0;
    last_out      = '0;
    @(posedge clk);
    #1;
    reset_now();

    // Basic add and low-slice carry crossing into the high slice.
    bus.out_ready = 1'b1;
    send(11'h7FF, 9'h1FE);
    drain();
    check_eq("basic_add", 32'(last_out), 32'h9FD);
    send(11'h03F, 9'h002);
    drain();
    check_eq("split_carry", 32'(last_out), 32'h041);

    // Streaming: eight back-to-back inputs must all be accepted without a stall.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      r            = $urandom;
      bus.in_s     = r[10:0];
      bus.in_c     = {r[19:12], 1'b0};
      bus.in_valid = 1'b1;
      step();
      check_eq("stream_accept", 32'(acc), 32'd1);
    end
    drain();

    // Backpressure: A and B fill the pipe, C is held until the consumer resumes.
    bus.out_ready = 1'b0;
    send(11'd5, 9'd2);
    send(11'd10, 9'd4);
    bus.in_s     = 11'd1;
    bus.in_c     = 9'd0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("c_held", 32'(acc), 32'd0);
      check_eq("bp_stable", 32'(bus.out_sum), 32'd7);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (acc) break;
    end
    check_eq("c_accepted", 32'(acc), 32'd1);
    drain();
    check_eq("bp_last", 32'(last_out), 32'd1);

    // Reset while a result is waiting at the output.
    bus.out_ready = 1'b0;
    send(11'd3, 9'd3);
    step();
    check_eq("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    reset_now();
    bus.out_ready = 1'b1;
    send(11'd3, 9'd4);
    drain();
    check_eq("post_rst_sum", 32'(last_out), 32'd7);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      r             = $urandom;
      bus.in_s      = r[10:0];
      bus.in_c      = {r[19:12], 1'b0};
      bus.in_valid  = r[20] | r[21];
      bus.out_ready = r[22] | r[23] | r[24];
      step();
    end
    drain();

`ifdef CSA_CPA_ERR_EN
    check_eq("err_clean", 32'(err_sticky), 32'd0);
    send(11'd0, 9'h001);
    check_eq("err_set", 32'(err_sticky), 32'd1);
    drain();
    check_eq("err_sum", 32'(last_out), 32'd1);
    send(11'd5, 9'd4);
    drain();
    check_eq("err_sticky_hold", 32'(err_sticky), 32'd1);
    reset_now();
    check_eq("err_reset", 32'(err_sticky), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
